dmem_access_ctrl: RTL

Clocked initiator for the word-wide asynchronous `sram` data-memory model. It sits between the MEM stage of the pipeline and the sram port. It accepts one load/store request at a time and drives `cs`/`oe`/`we`/`addr`/`din`. Byte and halfword stores are done as read-modify-write, because the sram has no byte enables. Loads are returned zero- or sign-extended, big-endian (MIPS), with a stall handshake.

---
 rtl/dmem_pkg.sv | 12 +
 rtl/mem_lane_align.sv | 50 +++++
 rtl/dmem_access_ctrl.sv | 136 +++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory access controller.
package dmem_pkg;
  localparam int RDW_W = 4;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_WR, S_RMW_RD, S_RMW_WR, S_RESP
  } state_t;
endpackage

// File: rtl/mem_lane_align.sv
// Big-endian lane steering: load extract/extend and read-modify-write merge.
module mem_lane_align
  import dmem_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_off,
  input  logic [1:0]  i_size,
  input  logic        i_signed,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic [31:0] o_merged
);
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = 8'h00;
    case (i_off)
      2'd0: w_byte = i_word[31:24];
      2'd1: w_byte = i_word[23:16];
      2'd2: w_byte = i_word[15:8];
      2'd3: w_byte = i_word[7:0];
      default: w_byte = 8'h00;
    endcase
    w_half   = i_off[1] ? i_word[15:0] : i_word[31:16];
    o_rdata  = i_word;
    o_merged = i_word;
    case (i_size)
      SZ_B: begin
        o_rdata = {{24{i_signed & w_byte[7]}}, w_byte};
        case (i_off)
          2'd0: o_merged[31:24] = i_wdata[7:0];
          2'd1: o_merged[23:16] = i_wdata[7:0];
          2'd2: o_merged[15:8]  = i_wdata[7:0];
          2'd3: o_merged[7:0]   = i_wdata[7:0];
          default: o_merged = i_word;
        endcase
      end
      SZ_H: begin
        o_rdata = {{16{i_signed & w_half[15]}}, w_half};
        if (i_off[1]) o_merged[15:0]  = i_wdata[15:0];
        else          o_merged[31:16] = i_wdata[15:0];
      end
      default: begin
        o_rdata  = i_word;
        o_merged = i_wdata;
      end
    endcase
  end
endmodule

// File: rtl/dmem_access_ctrl.sv
// Single-outstanding load/store initiator for the asynchronous word sram;
// sub-word stores are done as read-modify-write.
module dmem_access_ctrl
  import dmem_pkg::*;
#(
  parameter int RD_WAIT = 1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_we,
  input  logic [1:0]  i_req_size,
  input  logic        i_req_signed,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  output logic        o_resp_valid,
  output logic [31:0] o_resp_rdata,
  output logic        o_resp_misalign,
  output logic        o_mem_cs,
  output logic        o_mem_oe,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_din,
  input  logic [31:0] i_mem_dout
);
  localparam logic [RDW_W-1:0] WAIT_LD = RDW_W'(RD_WAIT - 1);

  state_t           r_state;
  logic             r_signed;
  logic [1:0]       r_size, r_off;
  logic [31:0]      r_wdata;
  logic [RDW_W-1:0] r_wait;
  logic             r_cs, r_oe, r_we, r_resp_valid, r_mis;
  logic [31:0]      r_addr, r_din, r_rdata;
  logic             w_misalign;
  logic [31:0]      w_rdata, w_merged;

  assign w_misalign = (i_req_size == 2'b11) ||
                      (i_req_size == SZ_H && i_req_addr[0]) ||
                      (i_req_size == SZ_W && i_req_addr[1:0] != 2'b00);

  mem_lane_align u_align (
    .i_word   (i_mem_dout),
    .i_off    (r_off),
    .i_size   (r_size),
    .i_signed (r_signed),
    .i_wdata  (r_wdata),
    .o_rdata  (w_rdata),
    .o_merged (w_merged)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_signed <= 1'b0; r_size <= SZ_B; r_off <= 2'b00; r_wdata <= '0;
      r_wait <= '0;
      r_cs <= 1'b0; r_oe <= 1'b0; r_we <= 1'b0;
      r_addr <= '0; r_din <= '0;
      r_resp_valid <= 1'b0; r_rdata <= '0; r_mis <= 1'b0;
    end else begin
      r_resp_valid <= 1'b0;
      case (r_state)
        S_IDLE: if (i_req_valid) begin
          r_signed <= i_req_signed;
          r_size   <= i_req_size;
          r_off    <= i_req_addr[1:0];
          r_wdata  <= i_req_wdata;
          if (w_misalign) begin
            r_resp_valid <= 1'b1;
            r_mis        <= 1'b1;
            r_rdata      <= '0;
            r_state      <= S_RESP;
          end else begin
            r_addr <= {i_req_addr[31:2], 2'b00};
            r_cs   <= 1'b1;
            r_wait <= WAIT_LD;
            if (!i_req_we) begin
              r_oe    <= 1'b1;
              r_state <= S_RD;
            end else if (i_req_size == SZ_W) begin
              r_we    <= 1'b1;
              r_din   <= i_req_wdata;
              r_state <= S_WR;
            end else begin
              r_oe    <= 1'b1;
              r_state <= S_RMW_RD;
            end
          end
        end
        // Read data is sampled at the edge that ends the last wait cycle.
        S_RD, S_RMW_RD: begin
          if (r_wait != '0) begin
            r_wait <= r_wait - 1'b1;
          end else begin
            r_oe <= 1'b0;
            if (r_state == S_RD) begin
              r_cs         <= 1'b0;
              r_rdata      <= w_rdata;
              r_mis        <= 1'b0;
              r_resp_valid <= 1'b1;
              r_state      <= S_RESP;
            end else begin
              r_we    <= 1'b1;
              r_din   <= w_merged;
              r_state <= S_RMW_WR;
            end
          end
        end
        S_WR, S_RMW_WR: begin
          r_cs         <= 1'b0;
          r_we         <= 1'b0;
          r_rdata      <= '0;
          r_mis        <= 1'b0;
          r_resp_valid <= 1'b1;
          r_state      <= S_RESP;
        end
        S_RESP: begin
          r_mis   <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_req_ready     = (r_state == S_IDLE);
  assign o_resp_valid    = r_resp_valid;
  assign o_resp_rdata    = r_rdata;
  assign o_resp_misalign = r_mis;
  assign o_mem_cs        = r_cs;
  assign o_mem_oe        = r_oe;
  assign o_mem_we        = r_we;
  assign o_mem_addr      = r_addr;
  assign o_mem_din       = r_din;
endmodule
